// File: rtl/riscv_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard/stall sequencer:
//   FSM state encoding, the x0 register index and the stage-control bundle.
// ---------------------------------------------------------------------------
package riscv_pipe_ctrl_pkg;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Enable/flush bundle for PC and the four stage registers.
    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic de_en;
        logic de_flush;
        logic em_en;
        logic mw_en;
        logic mem_wait;
    } ctrl_t;

    // Everything enabled, nothing flushed.
    function automatic ctrl_t ctrl_run();
        ctrl_t c;
        c          = '0;
        c.pc_en    = 1'b1;
        c.fd_en    = 1'b1;
        c.de_en    = 1'b1;
        c.em_en    = 1'b1;
        c.mw_en    = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/riscv_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// riscv_pipe_ctrl_if
//   Bundle between the 5-stage datapath and the pipeline controller.
//   master : datapath side (drives hazard/memory status, receives controls)
//   slave  : controller side
//   Hazard inputs : D rs1/rs2/rs_used, E rd/is_load/pc_sel, M mem_req,
//                   dmem_ready
//   Control outs  : pc/fd/de/em/mw enables, fd/de flushes, mem_wait,
//                   sticky mem_timeout
// ---------------------------------------------------------------------------
interface riscv_pipe_ctrl_if;
    logic [4:0] i_d_rs1_addr;
    logic [4:0] i_d_rs2_addr;
    logic [1:0] i_d_rs_used;
    logic [4:0] i_e_rd_addr;
    logic       i_e_is_load;
    logic       i_e_pc_sel;
    logic       i_m_mem_req;
    logic       i_dmem_ready;

    logic       o_pc_en;
    logic       o_fd_en;
    logic       o_fd_flush;
    logic       o_de_en;
    logic       o_de_flush;
    logic       o_em_en;
    logic       o_mw_en;
    logic       o_mem_wait;
    logic       o_mem_timeout;

    modport master (
        output i_d_rs1_addr, i_d_rs2_addr, i_d_rs_used, i_e_rd_addr,
               i_e_is_load, i_e_pc_sel, i_m_mem_req, i_dmem_ready,
        input  o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush,
               o_em_en, o_mw_en, o_mem_wait, o_mem_timeout
    );

    modport slave (
        input  i_d_rs1_addr, i_d_rs2_addr, i_d_rs_used, i_e_rd_addr,
               i_e_is_load, i_e_pc_sel, i_m_mem_req, i_dmem_ready,
        output o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush,
               o_em_en, o_mw_en, o_mem_wait, o_mem_timeout
    );
endinterface

// File: rtl/riscv_pipe_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// riscv_hazard_detect
//   Purely combinational load-use detector: the load in E writes a register
//   that the instruction in D actually reads. Writes to x0 never hazard.
//   Inputs : i_rs1_addr, i_rs2_addr, i_rs_used (bit0 rs1, bit1 rs2),
//            i_rd_addr, i_is_load
//   Output : o_load_use
// ---------------------------------------------------------------------------
module riscv_hazard_detect
    import riscv_pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    input  logic [1:0] i_rs_used,
    input  logic [4:0] i_rd_addr,
    input  logic       i_is_load,
    output logic       o_load_use
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = i_rs_used[0] & (i_rs1_addr == i_rd_addr);
    assign rs2_hit    = i_rs_used[1] & (i_rs2_addr == i_rd_addr);
    assign o_load_use = i_is_load & (i_rd_addr != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_pipe_ctrl
//   Hazard and stall sequencer for the F/D/E/M/W RV32I pipeline. Drives the
//   enable/flush of the PC and FD/DE/EM/MW registers, resolving:
//     - multi-cycle data-memory accesses in M (freeze whole pipe, with a
//       timeout watchdog that force-releases and sets a sticky flag),
//     - taken branches/jumps in E (flush FD and DE),
//     - load-use hazards (hold PC/FD, bubble into DE).
//   Ports:
//     i_clk, i_rstn : clock, async active-low reset (outputs forced 0 in reset)
//     bus           : riscv_pipe_ctrl_if.slave (hazard inputs, control outputs)
//     o_perf_stall_cnt / o_perf_flush_cnt : only with RISCV_PIPE_CTRL_PERF_EN
//   Parameters:
//     MEM_TIMEOUT (>=2) : wait cycles before forced release
//     TO_CNT_W          : counter width, 2**TO_CNT_W > MEM_TIMEOUT
//   Optional feature macro: RISCV_PIPE_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module riscv_pipe_ctrl
    import riscv_pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_CNT_W    = 5
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    riscv_pipe_ctrl_if.slave   bus
`ifdef RISCV_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        o_perf_stall_cnt,
    output logic [31:0]        o_perf_flush_cnt
`endif
);
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(MEM_TIMEOUT);
    localparam logic [TO_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_CNT_W-1:0] CNT_ONE  = TO_CNT_W'(1);

    state_e              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                to_q, to_d;

    logic  load_use;
    logic  timeout_hit;
    logic  freeze;
    ctrl_t ctrl;

    riscv_hazard_detect u_hazard (
        .i_rs1_addr (bus.i_d_rs1_addr),
        .i_rs2_addr (bus.i_d_rs2_addr),
        .i_rs_used  (bus.i_d_rs_used),
        .i_rd_addr  (bus.i_e_rd_addr),
        .i_is_load  (bus.i_e_is_load),
        .o_load_use (load_use)
    );

    assign timeout_hit = (cnt_q == TO_LIMIT);

    // In S_MEM_WAIT the freeze no longer looks at mem_req: the access was
    // already accepted and only ready or the watchdog can end it.
    assign freeze = ((state_q == S_RUN)      & bus.i_m_mem_req & ~bus.i_dmem_ready) |
                    ((state_q == S_MEM_WAIT) & ~bus.i_dmem_ready & ~timeout_hit);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            S_RUN: begin
                if (bus.i_m_mem_req & ~bus.i_dmem_ready) begin
                    state_d = S_MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_MEM_WAIT: begin
                if (bus.i_dmem_ready) begin
                    // Ready wins over a coincident timeout: normal completion.
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        ctrl = '0;
        if (!i_rstn) begin
            ctrl = '0;
        end else if (freeze) begin
            ctrl.mem_wait = 1'b1;
        end else if (bus.i_e_pc_sel) begin
            ctrl          = ctrl_run();
            ctrl.fd_flush = 1'b1;
            ctrl.de_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC/FD one cycle, bubble into DE; the load moves on to M
            // so the hazard is gone next cycle.
            ctrl          = ctrl_run();
            ctrl.pc_en    = 1'b0;
            ctrl.fd_en    = 1'b0;
            ctrl.de_flush = 1'b1;
        end else begin
            ctrl = ctrl_run();
        end
    end

    assign bus.o_pc_en       = ctrl.pc_en;
    assign bus.o_fd_en       = ctrl.fd_en;
    assign bus.o_fd_flush    = ctrl.fd_flush;
    assign bus.o_de_en       = ctrl.de_en;
    assign bus.o_de_flush    = ctrl.de_flush;
    assign bus.o_em_en       = ctrl.em_en;
    assign bus.o_mw_en       = ctrl.mw_en;
    assign bus.o_mem_wait    = ctrl.mem_wait;
    assign bus.o_mem_timeout = to_q;

`ifdef RISCV_PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(freeze | load_use);
            flush_cnt_q <= flush_cnt_q + 32'(bus.i_e_pc_sel & ~freeze);
        end
    end

    assign o_perf_stall_cnt = stall_cnt_q;
    assign o_perf_flush_cnt = flush_cnt_q;
`endif

endmodule
